// File: rtl/pcm_fifo_if.sv
// rtl/pcm_fifo_if.sv - PCM FIFO write-port and status bundle
interface pcm_fifo_if;
    logic [7:0] fifo_wrdata;
    logic       fifo_write;
    logic       fifo_reset;
    logic       fifo_full;
    logic       fifo_almost_empty;
    logic       fifo_empty;

    modport master (
        output fifo_wrdata, fifo_write, fifo_reset,
        input  fifo_full, fifo_almost_empty, fifo_empty
    );

    modport slave (
        input  fifo_wrdata, fifo_write, fifo_reset,
        output fifo_full, fifo_almost_empty, fifo_empty
    );
endinterface

// File: rtl/pcm_fifo_ctrl.sv
// rtl/pcm_fifo_ctrl.sv - PCM FIFO write-side arbiter, refill scheduler and reset sequencer
module pcm_fifo_ctrl #(
    parameter int RESET_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       host_wr,
    input  logic [7:0] host_wrdata,
    input  logic       stream_en,
    input  logic       stream_valid,
    input  logic [7:0] stream_data,
    output logic       stream_ack,
    input  logic       ctrl_fifo_reset,
    input  logic       irq_aflow_en,
    input  logic       overflow_clr,
    output logic       irq_aflow,
    output logic       overflow,
    output logic       busy,
    pcm_fifo_if.master fifo
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_RESET  = 2'd2,
        ST_SETTLE = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] wrdata_q, wrdata_d;
    logic       write_q, write_d;
    logic       freset_q, freset_d;
    logic       irq_q, irq_d;
    logic       ovf_q, ovf_d;
    logic       busy_d;

    // The !write_q term lets an in-flight write reach fifo_full before the next grant.
    assign stream_ack = (state_q == ST_FILL) && stream_valid && !host_wr &&
                        !ctrl_fifo_reset && !fifo.fifo_full && !write_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wrdata_d = wrdata_q;
        write_d  = 1'b0;
        freset_d = 1'b0;
        ovf_d    = overflow_clr ? 1'b0 : ovf_q;

        if (ctrl_fifo_reset) begin
            state_d  = ST_RESET;
            cnt_d    = 4'(RESET_CYCLES - 1);
            freset_d = 1'b1;
        end else begin
            case (state_q)
                ST_RESET: begin
                    if (cnt_q == 4'd0) begin
                        state_d = ST_SETTLE;
                    end else begin
                        cnt_d    = cnt_q - 4'd1;
                        freset_d = 1'b1;
                    end
                end
                ST_SETTLE: state_d = ST_IDLE;
                default: begin
                    if (host_wr) begin
                        if (fifo.fifo_full) begin
                            ovf_d = 1'b1;
                        end else begin
                            write_d  = 1'b1;
                            wrdata_d = host_wrdata;
                        end
                    end else if (stream_ack) begin
                        write_d  = 1'b1;
                        wrdata_d = stream_data;
                    end
                    if (state_q == ST_IDLE) begin
                        if (stream_en && (fifo.fifo_almost_empty || fifo.fifo_empty))
                            state_d = ST_FILL;
                    end else if (fifo.fifo_full || !stream_en) begin
                        state_d = ST_IDLE;
                    end
                end
            endcase
        end

        busy_d = (state_d == ST_RESET) || (state_d == ST_SETTLE);
        // Gated by the upcoming busy so the interrupt is low for every busy cycle.
        irq_d  = irq_aflow_en && fifo.fifo_almost_empty && !stream_en && !busy_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            wrdata_q <= 8'd0;
            write_q  <= 1'b0;
            freset_q <= 1'b0;
            irq_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wrdata_q <= wrdata_d;
            write_q  <= write_d;
            freset_q <= freset_d;
            irq_q    <= irq_d;
            ovf_q    <= ovf_d;
        end
    end

    assign fifo.fifo_wrdata = wrdata_q;
    assign fifo.fifo_write  = write_q;
    assign fifo.fifo_reset  = freset_q;
    assign irq_aflow        = irq_q;
    assign overflow         = ovf_q;
    assign busy             = (state_q == ST_RESET) || (state_q == ST_SETTLE);

endmodule

// File: tb/tb_pcm_fifo_ctrl.sv
// tb/tb_pcm_fifo_ctrl.sv - directed self-checking bench for pcm_fifo_ctrl
module tb_pcm_fifo_ctrl;
    logic       clk;
    logic       rst_n;
    logic       host_wr;
    logic [7:0] host_wrdata;
    logic       stream_en;
    logic       stream_valid;
    logic [7:0] stream_data;
    logic       stream_ack;
    logic       ctrl_fifo_reset;
    logic       irq_aflow_en;
    logic       overflow_clr;
    logic       irq_aflow;
    logic       overflow;
    logic       busy;

    int errors = 0;
    int checks = 0;

    pcm_fifo_if fif();

    pcm_fifo_ctrl #(.RESET_CYCLES(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .host_wr         (host_wr),
        .host_wrdata     (host_wrdata),
        .stream_en       (stream_en),
        .stream_valid    (stream_valid),
        .stream_data     (stream_data),
        .stream_ack      (stream_ack),
        .ctrl_fifo_reset (ctrl_fifo_reset),
        .irq_aflow_en    (irq_aflow_en),
        .overflow_clr    (overflow_clr),
        .irq_aflow       (irq_aflow),
        .overflow        (overflow),
        .busy            (busy),
        .fifo            (fif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        host_wr = 0; host_wrdata = 0; stream_en = 0; stream_valid = 0; stream_data = 0;
        ctrl_fifo_reset = 0; irq_aflow_en = 0; overflow_clr = 0;
        fif.fifo_full = 0; fif.fifo_almost_empty = 0; fif.fifo_empty = 0;
        #1;
        chk("rst_write", fif.fifo_write, 0);
        chk("rst_wrdata", fif.fifo_wrdata, 8'h00);
        chk("rst_reset", fif.fifo_reset, 0);
        chk("rst_busy", busy, 0);
        chk("rst_irq", irq_aflow, 0);
        chk("rst_ovf", overflow, 0);
        tick();
        rst_n = 1'b1;

        // Host write, FIFO not full
        host_wr = 1; host_wrdata = 8'hA5;
        tick();
        chk("host_write", fif.fifo_write, 1);
        chk("host_wrdata", fif.fifo_wrdata, 8'hA5);
        host_wr = 0;
        tick();
        chk("host_write_pulse", fif.fifo_write, 0);
        chk("host_wrdata_hold", fif.fifo_wrdata, 8'hA5);

        // Host write, FIFO full -> dropped, overflow set
        fif.fifo_full = 1; host_wr = 1; host_wrdata = 8'h3C;
        tick();
        chk("full_no_write", fif.fifo_write, 0);
        chk("full_ovf", overflow, 1);
        chk("full_wrdata", fif.fifo_wrdata, 8'hA5);
        overflow_clr = 1;
        tick();
        chk("ovf_set_wins", overflow, 1);
        host_wr = 0; fif.fifo_full = 0;
        tick();
        chk("ovf_clr", overflow, 0);
        overflow_clr = 0;

        // Refill hysteresis: one stream byte every second cycle
        stream_en = 1; stream_valid = 1; fif.fifo_almost_empty = 1; stream_data = 8'h40;
        #1;
        chk("idle_no_ack", stream_ack, 0);
        tick();
        chk("fill_ack", stream_ack, 1);
        chk("irq_masked", irq_aflow, 0);
        tick();
        chk("fill_write1", fif.fifo_write, 1);
        chk("fill_data1", fif.fifo_wrdata, 8'h40);
        chk("fill_ack_blocked", stream_ack, 0);
        stream_data = 8'h41;
        tick();
        chk("fill_gap", fif.fifo_write, 0);
        chk("fill_ack2", stream_ack, 1);
        tick();
        chk("fill_data2", fif.fifo_wrdata, 8'h41);
        tick();

        // Arbitration: host beats stream
        chk("arb_ack_pre", stream_ack, 1);
        host_wr = 1; host_wrdata = 8'h11;
        #1;
        chk("arb_ack_host", stream_ack, 0);
        tick();
        chk("arb_host_data", fif.fifo_wrdata, 8'h11);
        host_wr = 0;
        tick();
        chk("arb_stream_later", stream_ack, 1);
        tick();
        chk("arb_stream_data", fif.fifo_wrdata, 8'h41);

        // Full ends refill; no re-entry without almost_empty
        fif.fifo_full = 1;
        #1;
        chk("full_ack", stream_ack, 0);
        tick();
        fif.fifo_full = 0; fif.fifo_almost_empty = 0;
        #1;
        chk("hyst_idle", stream_ack, 0);
        tick();
        chk("hyst_stay_idle", stream_ack, 0);

        // Reset asserted mid-FILL with a write in flight
        fif.fifo_almost_empty = 1;
        tick();
        chk("refill_ack", stream_ack, 1);
        tick();
        chk("refill_write", fif.fifo_write, 1);
        rst_n = 0;
        #1;
        chk("async_write", fif.fifo_write, 0);
        chk("async_wrdata", fif.fifo_wrdata, 8'h00);
        fif.fifo_almost_empty = 0;
        tick();
        rst_n = 1;
        tick();
        chk("post_rst_idle", stream_ack, 0);
        stream_en = 0; stream_valid = 0;

        // FIFO reset sequencing with same-cycle host write
        ctrl_fifo_reset = 1; host_wr = 1; host_wrdata = 8'h77;
        tick();
        chk("frst_reset0", fif.fifo_reset, 1);
        chk("frst_busy0", busy, 1);
        chk("frst_write0", fif.fifo_write, 0);
        ctrl_fifo_reset = 0; fif.fifo_full = 1;
        for (int i = 1; i < 4; i++) begin
            tick();
            chk("frst_reset", fif.fifo_reset, 1);
            chk("frst_busy", busy, 1);
            chk("frst_write", fif.fifo_write, 0);
        end
        tick();
        chk("frst_reset_low", fif.fifo_reset, 0);
        chk("frst_settle_busy", busy, 1);
        tick();
        chk("frst_done", busy, 0);
        chk("frst_no_write", fif.fifo_write, 0);
        chk("frst_ovf", overflow, 0);
        host_wr = 0; fif.fifo_full = 0;

        // Restarted reset
        ctrl_fifo_reset = 1;
        tick();
        ctrl_fifo_reset = 0;
        tick();
        ctrl_fifo_reset = 1;
        tick();
        ctrl_fifo_reset = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rerst_reset", fif.fifo_reset, 1);
        end
        tick();
        chk("rerst_low", fif.fifo_reset, 0);
        chk("rerst_busy", busy, 1);
        tick();
        chk("rerst_done", busy, 0);

        // Interrupt
        irq_aflow_en = 1; fif.fifo_almost_empty = 1;
        tick();
        chk("irq_set", irq_aflow, 1);
        stream_en = 1;
        tick();
        chk("irq_masked_en", irq_aflow, 0);
        stream_en = 0;
        tick();
        chk("irq_reset", irq_aflow, 1);
        ctrl_fifo_reset = 1;
        tick();
        ctrl_fifo_reset = 0;
        chk("irq_busy0", irq_aflow, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("irq_busy", irq_aflow, 0);
        end
        tick();
        chk("irq_after_busy", irq_aflow, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pcm_fifo_ctrl.md
Name: pcm_fifo_ctrl

Overview:
- Write-side controller for the PCM audio FIFO.
- Shares the single FIFO write port between host register writes and a streaming requester that pulls PCM bytes from VRAM.
- Schedules streaming refills with almost_empty/full hysteresis, sequences multi-cycle FIFO resets, and generates the AFLOW interrupt and a sticky overflow flag.
- Sits between the register file / stream engine and the pcm block's fifo_wrdata/fifo_write/fifo_reset/status pins.

Parameters:
RESET_CYCLES, 4, cycles fifo_reset is held high per reset request; legal range 1..15.

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
host_wr  in  1  one-cycle host write strobe to the audio data register
host_wrdata  in  8  host write byte
stream_en  in  1  streaming refill enabled
stream_valid  in  1  stream engine has a byte available
stream_data  in  8  stream byte
stream_ack  out  1  stream byte consumed this cycle (combinational)
ctrl_fifo_reset  in  1  one-cycle FIFO reset request from the control register
irq_aflow_en  in  1  AFLOW interrupt enable
overflow_clr  in  1  clears overflow flag
fifo_full  in  1  FIFO status
fifo_almost_empty  in  1  FIFO status
fifo_empty  in  1  FIFO status
fifo_wrdata  out  8  FIFO write data (registered)
fifo_write  out  1  FIFO write strobe (registered)
fifo_reset  out  1  FIFO reset (registered)
irq_aflow  out  1  AFLOW interrupt level (registered)
overflow  out  1  sticky: host byte dropped because FIFO full
busy  out  1  high in RESET/SETTLE

Behaviour:
- Reset (rst_n low, async): all outputs 0; state IDLE; reset counter 0; fifo_wrdata 0.
- States: IDLE (no refill), FILL (streaming refill active), RESET, SETTLE.
- Priority each cycle, highest first:
  1. ctrl_fifo_reset.
  2. host_wr.
  3. stream grant.
- Transitions:
  - ctrl_fifo_reset in any state: go to RESET, counter <= RESET_CYCLES-1, fifo_reset <= 1. Any same-cycle host_wr is dropped without setting overflow. A reset request during RESET restarts the count.
  - RESET: counter decrements each cycle; at 0, fifo_reset <= 0 and go to SETTLE. fifo_reset is therefore high exactly RESET_CYCLES cycles.
  - SETTLE: one cycle, then IDLE.
  - In RESET and SETTLE: host writes are dropped silently (no overflow), stream_ack=0, fifo_write=0.
  - IDLE -> FILL when stream_en && fifo_almost_empty.
  - FILL -> IDLE when fifo_full or !stream_en.
- Host write (IDLE/FILL):
  - If !fifo_full: fifo_write <= 1, fifo_wrdata <= host_wrdata (latency 1 cycle).
  - If fifo_full: byte dropped, overflow <= 1.
  - Host is never stalled.
- Stream grant:
  - stream_ack = (state==FILL) && stream_valid && !host_wr && !ctrl_fifo_reset && !fifo_full && !fifo_write.
  - The !fifo_write term blocks back-to-back stream writes, so a write in flight is reflected in fifo_full before the next grant. Maximum stream rate is 1 byte / 2 cycles.
  - On ack: fifo_write <= 1, fifo_wrdata <= stream_data.
- fifo_write is a single-cycle pulse; it deasserts the cycle after it is issued unless a new write is issued.
- fifo_wrdata holds its last value when no write is issued.
- A host write with a write in flight is still forwarded if !fifo_full. The FIFO ignores writes when full; overflow reflects only host writes that see fifo_full=1.
- overflow:
  - Set takes precedence over overflow_clr in the same cycle.
  - Unaffected by FIFO reset; cleared only by overflow_clr or rst_n.
- irq_aflow <= irq_aflow_en && fifo_almost_empty && !stream_en && !busy. It is a level signal, masked while streaming is enabled (the streamer owns refill).
- busy = (state==RESET || state==SETTLE), registered with state.
- fifo_empty is used only for the IDLE->FILL check, as fifo_almost_empty || fifo_empty.

Test Plan:
- Reset: rst_n low mid-FILL with fifo_write=1 -> all outputs 0 immediately, state IDLE after release.
- Host write: host_wr=1, data 0xA5, fifo_full=0 -> next cycle fifo_write=1, fifo_wrdata=0xA5, for one cycle. Repeat with fifo_full=1 -> fifo_write stays 0, overflow=1. overflow_clr and a full-FIFO host_wr in the same cycle -> overflow stays 1.
- Refill hysteresis: stream_en=1, stream_valid=1 held, fifo_almost_empty=1 -> FILL; stream_ack pulses every 2nd cycle. Raise fifo_full -> stream_ack 0, state IDLE. Drop full with almost_empty=0 -> stays IDLE.
- Arbitration: FILL, stream_valid=1, host_wr=1 with 0x11 -> stream_ack=0, next cycle fifo_wrdata=0x11. Stream is granted on a later cycle.
- FIFO reset sequencing: RESET_CYCLES=4, ctrl_fifo_reset pulse with simultaneous host_wr -> fifo_reset high exactly 4 cycles, busy high 5 cycles, no fifo_write, overflow unchanged. Second reset at cycle 2 -> fifo_reset extends to 4 cycles from the second request.
- Interrupt: irq_aflow_en=1, almost_empty=1, stream_en=0 -> irq_aflow=1 next cycle. Set stream_en=1 -> irq_aflow=0 next cycle. Assert ctrl_fifo_reset -> irq_aflow=0 during busy.
